// File: rtl/life_scan_ctrl_if.sv
// Host-side command/response handshake for the life tile scan sequencer.
// master = host (UART or harness), slave = life_scan_ctrl.
interface life_scan_ctrl_if #(
   parameter int CELLS = 16,
   parameter int GEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CELLS-1:0] cmd_data;
   logic [GEN_W-1:0] cmd_gens;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [CELLS-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_gens, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_gens, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/life_scan_ctrl.sv
// Command sequencer for one 4x4 life tile: drives the tile scan chain for LOAD/READ/SWAP
// and the run enable for STEP. Every output comes straight from a flop.
module life_scan_ctrl #(
   parameter int CELLS = 16,
   parameter int GEN_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   life_scan_ctrl_if.slave host,
   output logic            done,
   output logic            busy,
   output logic            scan,
   output logic            scan_write_val,
   output logic            scan_write_enb,
   input  logic            scan_read_val,
   output logic            run
);
   localparam int CW = $clog2(CELLS);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(CELLS - 1);
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_STEP = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RUN, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CELLS-1:0] pat_q, pat_d;
   logic [CELLS-1:0] rsp_data_q, rsp_data_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             scan_q, scan_d;
   logic             wval_q, wval_d;
   logic             wenb_q, wenb_d;
   logic             run_q, run_d;
   logic             done_q, done_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      pat_d       = pat_q;
      rsp_data_d  = rsp_data_q;
      cnt_d       = cnt_q;
      gen_d       = gen_q;
      scan_d      = 1'b0;
      wval_d      = 1'b0;
      wenb_d      = 1'b0;
      run_d       = 1'b0;
      done_d      = 1'b0;
      rsp_valid_d = 1'b0;
      cmd_ready_d = 1'b0;
      busy_d      = 1'b1;
      cnt_nxt     = cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            if (host.cmd_valid && cmd_ready_q) begin
               op_d        = host.cmd_op;
               pat_d       = host.cmd_data;
               gen_d       = host.cmd_gens;
               cnt_d       = '0;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (host.cmd_op == OP_STEP) begin
                  // A zero count still spends one RUN cycle to pulse done.
                  state_d = S_RUN;
                  run_d   = (host.cmd_gens != '0);
                  done_d  = (host.cmd_gens == '0);
               end else begin
                  state_d = S_SHIFT;
                  scan_d  = 1'b1;
                  wenb_d  = (host.cmd_op != OP_READ);
                  wval_d  = (host.cmd_op != OP_READ) && host.cmd_data[0];
               end
            end
         end

         S_SHIFT: begin
            if (!scan_q) begin
               // Post-LOAD done cycle has already been presented.
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               cnt_d = cnt_nxt;
               if (op_q != OP_LOAD) rsp_data_d[cnt_q] = scan_read_val;
               if (cnt_q == LAST_SHIFT) begin
                  done_d = 1'b1;
                  if (op_q != OP_LOAD) begin
                     state_d     = S_RESP;
                     rsp_valid_d = 1'b1;
                  end
               end else begin
                  scan_d = 1'b1;
                  wenb_d = (op_q != OP_READ);
                  wval_d = (op_q != OP_READ) && pat_q[cnt_nxt];
               end
            end
         end

         S_RUN: begin
            if (gen_q > GEN_W'(1)) begin
               gen_d = gen_q - 1'b1;
               run_d = 1'b1;
            end else if (gen_q == GEN_W'(1)) begin
               gen_d  = '0;
               done_d = 1'b1;
            end else begin
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end

         S_RESP: begin
            rsp_valid_d = 1'b1;
            if (host.rsp_ready && rsp_valid_q) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         pat_q       <= '0;
         rsp_data_q  <= '0;
         cnt_q       <= '0;
         gen_q       <= '0;
         scan_q      <= 1'b0;
         wval_q      <= 1'b0;
         wenb_q      <= 1'b0;
         run_q       <= 1'b0;
         done_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pat_q       <= pat_d;
         rsp_data_q  <= rsp_data_d;
         cnt_q       <= cnt_d;
         gen_q       <= gen_d;
         scan_q      <= scan_d;
         wval_q      <= wval_d;
         wenb_q      <= wenb_d;
         run_q       <= run_d;
         done_q      <= done_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign host.cmd_ready = cmd_ready_q;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign done           = done_q;
   assign busy           = busy_q;
   assign scan           = scan_q;
   assign scan_write_val = wval_q;
   assign scan_write_enb = wenb_q;
   assign run            = run_q;
endmodule

// File: tb/tb_life_scan_ctrl.sv
// Directed bench for life_scan_ctrl with a behavioural 4x4 life tile on the scan chain
// (zero neighbours at the tile edges).
module tb_life_scan_ctrl;
   localparam int CELLS = 16;
   localparam int GEN_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic done, busy, scan, scan_write_val, scan_write_enb, scan_read_val, run;
   logic [CELLS-1:0] tile_q = '0;
   int total = 0;
   int bad = 0;
   int viol = 0;
   int done_cnt = 0;

   life_scan_ctrl_if #(.CELLS(CELLS), .GEN_W(GEN_W)) hif();

   life_scan_ctrl #(.CELLS(CELLS), .GEN_W(GEN_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .host           (hif),
      .done           (done),
      .busy           (busy),
      .scan           (scan),
      .scan_write_val (scan_write_val),
      .scan_write_enb (scan_write_enb),
      .scan_read_val  (scan_read_val),
      .run            (run)
   );

   always #5 clk = ~clk;

   assign scan_read_val = tile_q[0];

   function automatic logic [15:0] life_step(input logic [15:0] t);
      logic [15:0] n;
      n = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            int k;
            k = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
                     k += int'(t[(r + dr) * 4 + c + dc]);
               end
            end
            n[r * 4 + c] = (k == 3) || (t[r * 4 + c] && k == 2);
         end
      end
      return n;
   endfunction

   // Chain: head enters at bit 15, tail is bit 0.
   always @(posedge clk) begin
      if (run)
         tile_q <= life_step(tile_q);
      else if (scan)
         tile_q <= {(scan_write_enb ? scan_write_val : tile_q[0]), tile_q[15:1]};
   end

   always @(negedge clk) begin
      viol <= viol + int'(scan && run) + int'(!scan && scan_write_enb)
                   + int'(!scan_write_enb && scan_write_val);
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] data, input logic [7:0] gens,
                        output int lat, output int scans, output int runs, output int busies,
                        output logic [15:0] rd, output logic rv);
      @(negedge clk);
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = op;
      hif.cmd_data  = data;
      hif.cmd_gens  = gens;
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b0;
      hif.cmd_data  = '0;
      hif.cmd_gens  = '0;
      lat = 0; scans = 0; runs = 0; busies = 0; rd = '0; rv = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         scans  += int'(scan);
         runs   += int'(run);
         busies += int'(busy);
         if (done) begin
            lat = n;
            rd  = hif.rsp_data;
            rv  = hif.rsp_valid;
            break;
         end
      end
   endtask

   initial begin
      int lat, scans, runs, busies, dc0;
      logic [15:0] rd;
      logic rv;

      hif.cmd_valid = 1'b0;
      hif.cmd_op    = 2'b00;
      hif.cmd_data  = '0;
      hif.cmd_gens  = '0;
      hif.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", hif.cmd_ready, 1);
      chk("rst_outputs", {busy, scan, run, done, hif.rsp_valid, scan_write_enb, scan_write_val}, 0);
      chk("rst_rsp_data", hif.rsp_data, 0);
      reset = 1'b1;

      issue(2'b00, 16'hA5C3, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("load_lat", lat, 17);
      chk("load_scans", scans, 16);
      chk("load_tile", tile_q, 16'hA5C3);

      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("read_lat", lat, 17);
      chk("read_scans", scans, 16);
      chk("read_valid", rv, 1);
      chk("read_data", rd, 16'hA5C3);

      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("reread_data", rd, 16'hA5C3);
      chk("reread_tile", tile_q, 16'hA5C3);

      issue(2'b00, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      issue(2'b11, 16'hFFFF, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("swap_lat", lat, 17);
      chk("swap_valid", rv, 1);
      chk("swap_old", rd, 16'h0000);
      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("swap_new", rd, 16'hFFFF);

      issue(2'b00, 16'h0222, 8'd0, lat, scans, runs, busies, rd, rv);
      issue(2'b01, 16'h0000, 8'd1, lat, scans, runs, busies, rd, rv);
      chk("step1_lat", lat, 2);
      chk("step1_runs", runs, 1);
      chk("step1_scans", scans, 0);
      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("step1_read", rd, 16'h0070);

      issue(2'b00, 16'h0222, 8'd0, lat, scans, runs, busies, rd, rv);
      issue(2'b01, 16'h0000, 8'd2, lat, scans, runs, busies, rd, rv);
      chk("step2_lat", lat, 3);
      chk("step2_runs", runs, 2);
      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("step2_read", rd, 16'h0222);

      issue(2'b01, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("step0_lat", lat, 1);
      chk("step0_runs", runs, 0);
      chk("step0_busy_cycles", busies, 1);
      @(negedge clk);
      chk("step0_idle_after", {busy, hif.cmd_ready}, 2'b01);

      hif.rsp_ready = 1'b0;
      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("hold_lat", lat, 17);
      chk("hold_first_data", rd, 16'h0222);
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = 2'b00;
      hif.cmd_data  = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", hif.rsp_valid, 1);
         chk("hold_data", hif.rsp_data, 16'h0222);
         chk("hold_cmd_ready", hif.cmd_ready, 0);
      end
      hif.cmd_valid = 1'b0;
      hif.cmd_data  = '0;
      hif.rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release", {hif.rsp_valid, busy, hif.cmd_ready}, 3'b001);
      chk("hold_tile", tile_q, 16'h0222);

      // Abort a LOAD during shift cycle 7 (cycle T+8).
      @(negedge clk);
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = 2'b00;
      hif.cmd_data  = 16'hFFFF;
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b0;
      hif.cmd_data  = '0;
      repeat (8) @(negedge clk);
      chk("abort_in_shift", scan, 1);
      reset = 1'b0;
      #1;
      dc0 = done_cnt;
      chk("abort_cmd_ready", hif.cmd_ready, 1);
      chk("abort_outputs", {busy, scan, run, done, hif.rsp_valid, scan_write_enb, scan_write_val}, 0);
      chk("abort_rsp_data", hif.rsp_data, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt, dc0);

      issue(2'b00, 16'h1234, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("post_abort_load_lat", lat, 17);
      issue(2'b10, 16'h0000, 8'd0, lat, scans, runs, busies, rd, rv);
      chk("post_abort_read", rd, 16'h1234);

      @(negedge clk);
      chk("exclusivity", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
